// File: rtl/dht_frame_checker_pkg.sv
// Shared types and constants for the DHT11 frame checker: state encoding,
// frame byte offsets and the double-dabble nibble correction.
package dht_frame_checker_pkg;

  typedef enum logic [1:0] {StIdle, StCheck, StConv, StOut} state_e;

  localparam int unsigned HUM_INT_OFS   = 32;
  localparam int unsigned HUM_FRAC_OFS  = 24;
  localparam int unsigned TEMP_INT_OFS  = 16;
  localparam int unsigned TEMP_FRAC_OFS = 8;
  localparam int unsigned CHK_OFS       = 0;

  localparam int unsigned BCD_W     = 12;
  localparam int unsigned BCD_ITERS = 8;

  // Add 3 to every BCD nibble >= 5 so the following left shift carries correctly.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one shift per cycle).
module bin2bcd8
  import dht_frame_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       value,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [7:0]       bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= value;
      bcd_q <= '0;
      cnt_q <= 4'(BCD_ITERS);
    end else if (cnt_q != 4'd0) begin
      bcd_q <= 12'({bcd_adjust(bcd_q), bin_q[7]});
      bin_q <= {bin_q[6:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // High during the final iteration; bcd holds the result from the next cycle on.
  assign done = (cnt_q == 4'd1);
  assign bcd  = bcd_q;

endmodule

// File: rtl/dht_frame_checker.sv
// DHT11 frame checksum checker with held readings and optional BCD conversion.
// Define DHT_BCD_EN to build the CONV stage and drive HUM_BCD/TEMP_BCD.
module dht_frame_checker
  import dht_frame_checker_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [39:0]          FRAME_IN,
  input  logic                 FRAME_VLD,
  output logic                 BUSY,
  output logic [7:0]           HUM_INT,
  output logic [7:0]           HUM_FLOAT,
  output logic [7:0]           TEMP_INT,
  output logic [7:0]           TEMP_FLOAT,
  output logic [BCD_W-1:0]     HUM_BCD,
  output logic [BCD_W-1:0]     TEMP_BCD,
  output logic                 DATA_VLD,
  output logic                 CRC_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  state_e               state_q, state_d;
  logic [39:0]          frame_q;
  logic [7:0]           hum_int_q, hum_frac_q, temp_int_q, temp_frac_q;
  logic                 data_vld_q, crc_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [9:0]           sum;
  logic                 crc_ok;

  assign sum = 10'(frame_q[HUM_INT_OFS +: 8]) + 10'(frame_q[HUM_FRAC_OFS +: 8])
             + 10'(frame_q[TEMP_INT_OFS +: 8]) + 10'(frame_q[TEMP_FRAC_OFS +: 8]);
  // Only the low byte of the sum is checked, so wrap-around is legal.
  assign crc_ok = (8'(sum) == frame_q[CHK_OFS +: 8]);

`ifdef DHT_BCD_EN
  logic             conv_start, hum_done, temp_done;
  logic [BCD_W-1:0] hum_bcd, temp_bcd, hum_bcd_q, temp_bcd_q;

  bin2bcd8 u_hum_bcd (
    .clk   (CLK),
    .rst   (RST),
    .start (conv_start),
    .value (frame_q[HUM_INT_OFS +: 8]),
    .done  (hum_done),
    .bcd   (hum_bcd)
  );

  bin2bcd8 u_temp_bcd (
    .clk   (CLK),
    .rst   (RST),
    .start (conv_start),
    .value (frame_q[TEMP_INT_OFS +: 8]),
    .done  (temp_done),
    .bcd   (temp_bcd)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      hum_bcd_q  <= '0;
      temp_bcd_q <= '0;
    end else if (state_q == StOut) begin
      hum_bcd_q  <= hum_bcd;
      temp_bcd_q <= temp_bcd;
    end
  end

  assign HUM_BCD  = hum_bcd_q;
  assign TEMP_BCD = temp_bcd_q;
`else
  assign HUM_BCD  = '0;
  assign TEMP_BCD = '0;
`endif

  always_comb begin
    state_d = state_q;
`ifdef DHT_BCD_EN
    conv_start = 1'b0;
`endif
    unique case (state_q)
      StIdle:  if (FRAME_VLD) state_d = StCheck;
      StCheck: begin
        if (!crc_ok) begin
          state_d = StIdle;
        end else begin
`ifdef DHT_BCD_EN
          conv_start = 1'b1;
          state_d    = StConv;
`else
          state_d    = StOut;
`endif
        end
      end
`ifdef DHT_BCD_EN
      StConv:  if (hum_done && temp_done) state_d = StOut;
`else
      StConv:  state_d = StIdle;
`endif
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      frame_q     <= '0;
      hum_int_q   <= '0;
      hum_frac_q  <= '0;
      temp_int_q  <= '0;
      temp_frac_q <= '0;
      data_vld_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      data_vld_q <= 1'b0;
      crc_err_q  <= 1'b0;
      if (state_q == StIdle && FRAME_VLD) frame_q <= FRAME_IN;
      if (state_q == StCheck && !crc_ok) begin
        crc_err_q <= 1'b1;
        if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
      if (state_q == StOut) begin
        hum_int_q   <= frame_q[HUM_INT_OFS +: 8];
        hum_frac_q  <= frame_q[HUM_FRAC_OFS +: 8];
        temp_int_q  <= frame_q[TEMP_INT_OFS +: 8];
        temp_frac_q <= frame_q[TEMP_FRAC_OFS +: 8];
        data_vld_q  <= 1'b1;
      end
    end
  end

  assign BUSY       = (state_q != StIdle);
  assign HUM_INT    = hum_int_q;
  assign HUM_FLOAT  = hum_frac_q;
  assign TEMP_INT   = temp_int_q;
  assign TEMP_FLOAT = temp_frac_q;
  assign DATA_VLD   = data_vld_q;
  assign CRC_ERR    = crc_err_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_dht_frame_checker.sv
// Directed self-checking bench for dht_frame_checker (works with or without DHT_BCD_EN).
module tb_dht_frame_checker;

`ifdef DHT_BCD_EN
  localparam bit BcdEn    = 1'b1;
  localparam int Lat      = 10;
  localparam int DropEdge = 3;
  localparam int RstEdge  = 5;
`else
  localparam bit BcdEn    = 1'b0;
  localparam int Lat      = 2;
  localparam int DropEdge = 1;
  localparam int RstEdge  = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [39:0] FRAME_IN = '0;
  logic        FRAME_VLD = 1'b0;
  logic        BUSY, DATA_VLD, CRC_ERR;
  logic [7:0]  HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, ERR_CNT;
  logic [11:0] HUM_BCD, TEMP_BCD;

  int checks = 0;
  int failures = 0;

  dht_frame_checker #(.ERR_CNT_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FRAME_IN   (FRAME_IN),
    .FRAME_VLD  (FRAME_VLD),
    .BUSY       (BUSY),
    .HUM_INT    (HUM_INT),
    .HUM_FLOAT  (HUM_FLOAT),
    .TEMP_INT   (TEMP_INT),
    .TEMP_FLOAT (TEMP_FLOAT),
    .HUM_BCD    (HUM_BCD),
    .TEMP_BCD   (TEMP_BCD),
    .DATA_VLD   (DATA_VLD),
    .CRC_ERR    (CRC_ERR),
    .ERR_CNT    (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Called #1 after an edge; presents the frame so it is sampled at the next edge (edge 0).
  task automatic send(input logic [39:0] f);
    FRAME_IN  = f;
    FRAME_VLD = 1'b1;
    @(posedge CLK); #1;
    FRAME_VLD = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (DATA_VLD !== 1'b0) begin failures++; $display("FAIL reset_data_vld got=%b exp=0", DATA_VLD); end
    checks++; if (CRC_ERR !== 1'b0) begin failures++; $display("FAIL reset_crc_err got=%b exp=0", CRC_ERR); end
    checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%h exp=00", ERR_CNT); end
    checks++;
    if ({HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, HUM_BCD, TEMP_BCD} !== 56'd0) begin
      failures++;
      $display("FAIL reset_data got=%h %h %h %h %h %h exp=all zero",
               HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, HUM_BCD, TEMP_BCD);
    end
    // A frame strobe coincident with reset must be ignored.
    FRAME_IN = 40'h3700190050; FRAME_VLD = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; FRAME_VLD = 1'b0;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL vld_in_reset_busy got=%b exp=0", BUSY); end
    begin
      int vld = 0;
      for (int e = 0; e < Lat + 3; e++) begin
        @(posedge CLK); #1;
        if (DATA_VLD === 1'b1) vld++;
      end
      checks++; if (vld !== 0) begin failures++; $display("FAIL vld_in_reset_pulses got=%0d exp=0", vld); end
    end
  endtask

  task automatic test_good_frame();
    int early = 0;
    send(40'h3700190050);
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL good_busy_edge0 got=%b exp=1", BUSY); end
    for (int e = 1; e < Lat; e++) begin
      @(posedge CLK); #1;
      if (DATA_VLD !== 1'b0 || BUSY !== 1'b1) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL good_early_vld_or_idle got=%0d exp=0", early); end
    @(posedge CLK); #1;
    checks++; if (DATA_VLD !== 1'b1) begin failures++; $display("FAIL good_data_vld got=%b exp=1", DATA_VLD); end
    checks++; if (HUM_INT !== 8'h37) begin failures++; $display("FAIL good_hum_int got=%h exp=37", HUM_INT); end
    checks++; if (HUM_FLOAT !== 8'h00) begin failures++; $display("FAIL good_hum_float got=%h exp=00", HUM_FLOAT); end
    checks++; if (TEMP_INT !== 8'h19) begin failures++; $display("FAIL good_temp_int got=%h exp=19", TEMP_INT); end
    checks++; if (TEMP_FLOAT !== 8'h00) begin failures++; $display("FAIL good_temp_float got=%h exp=00", TEMP_FLOAT); end
    checks++;
    if (HUM_BCD !== (BcdEn ? 12'h055 : 12'h000)) begin
      failures++; $display("FAIL good_hum_bcd got=%h exp=%h", HUM_BCD, BcdEn ? 12'h055 : 12'h000);
    end
    checks++;
    if (TEMP_BCD !== (BcdEn ? 12'h025 : 12'h000)) begin
      failures++; $display("FAIL good_temp_bcd got=%h exp=%h", TEMP_BCD, BcdEn ? 12'h025 : 12'h000);
    end
    checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("FAIL good_err_cnt got=%h exp=00", ERR_CNT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL good_busy_done got=%b exp=0", BUSY); end
    @(posedge CLK); #1;
    checks++; if (DATA_VLD !== 1'b0) begin failures++; $display("FAIL good_vld_one_cycle got=%b exp=0", DATA_VLD); end
  endtask

  task automatic test_bad_frame();
    int vld = 0;
    int crc = 0;
    send(40'h3700190051);
    @(posedge CLK); #1;
    checks++; if (CRC_ERR !== 1'b1) begin failures++; $display("FAIL bad_crc_err got=%b exp=1", CRC_ERR); end
    checks++; if (ERR_CNT !== 8'd1) begin failures++; $display("FAIL bad_err_cnt got=%h exp=01", ERR_CNT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL bad_busy got=%b exp=0", BUSY); end
    for (int e = 2; e < 14; e++) begin
      @(posedge CLK); #1;
      if (DATA_VLD === 1'b1) vld++;
      if (CRC_ERR === 1'b1) crc++;
    end
    checks++; if (vld !== 0) begin failures++; $display("FAIL bad_no_data_vld got=%0d exp=0", vld); end
    checks++; if (crc !== 0) begin failures++; $display("FAIL bad_crc_one_cycle got=%0d exp=0", crc); end
    checks++; if (HUM_INT !== 8'h37) begin failures++; $display("FAIL bad_hum_held got=%h exp=37", HUM_INT); end
    checks++; if (TEMP_INT !== 8'h19) begin failures++; $display("FAIL bad_temp_held got=%h exp=19", TEMP_INT); end
  endtask

  task automatic test_checksum_wrap();
    send(40'hFFFF020000);
    repeat (Lat) @(posedge CLK);
    #1;
    checks++; if (DATA_VLD !== 1'b1) begin failures++; $display("FAIL wrap_data_vld got=%b exp=1", DATA_VLD); end
    checks++; if (HUM_INT !== 8'hFF) begin failures++; $display("FAIL wrap_hum_int got=%h exp=ff", HUM_INT); end
    checks++; if (HUM_FLOAT !== 8'hFF) begin failures++; $display("FAIL wrap_hum_float got=%h exp=ff", HUM_FLOAT); end
    checks++; if (TEMP_INT !== 8'h02) begin failures++; $display("FAIL wrap_temp_int got=%h exp=02", TEMP_INT); end
    checks++;
    if (HUM_BCD !== (BcdEn ? 12'h255 : 12'h000)) begin
      failures++; $display("FAIL wrap_hum_bcd got=%h exp=%h", HUM_BCD, BcdEn ? 12'h255 : 12'h000);
    end
    checks++;
    if (TEMP_BCD !== (BcdEn ? 12'h002 : 12'h000)) begin
      failures++; $display("FAIL wrap_temp_bcd got=%h exp=%h", TEMP_BCD, BcdEn ? 12'h002 : 12'h000);
    end
    checks++; if (ERR_CNT !== 8'd1) begin failures++; $display("FAIL wrap_err_cnt got=%h exp=01", ERR_CNT); end
    @(posedge CLK); #1;
  endtask

  task automatic test_busy_drop();
    int vld = 0;
    int vld_edge = -1;
    int crc = 0;
    send(40'h3700190050);
    for (int e = 1; e <= 16; e++) begin
      if (e == DropEdge) begin FRAME_IN = 40'h0A00140024; FRAME_VLD = 1'b1; end
      @(posedge CLK); #1;
      if (e == DropEdge) FRAME_VLD = 1'b0;
      if (DATA_VLD === 1'b1) begin vld++; vld_edge = e; end
      if (CRC_ERR === 1'b1) crc++;
    end
    checks++; if (vld !== 1) begin failures++; $display("FAIL drop_vld_count got=%0d exp=1", vld); end
    checks++; if (vld_edge !== Lat) begin failures++; $display("FAIL drop_vld_edge got=%0d exp=%0d", vld_edge, Lat); end
    checks++; if (crc !== 0) begin failures++; $display("FAIL drop_crc_count got=%0d exp=0", crc); end
    checks++; if (ERR_CNT !== 8'd1) begin failures++; $display("FAIL drop_err_cnt got=%h exp=01", ERR_CNT); end
    checks++; if (HUM_INT !== 8'h37) begin failures++; $display("FAIL drop_hum_int got=%h exp=37", HUM_INT); end
    checks++; if (TEMP_INT !== 8'h19) begin failures++; $display("FAIL drop_temp_int got=%h exp=19", TEMP_INT); end
  endtask

  task automatic test_reset_mid_frame();
    int vld = 0;
    send(40'h3700190050);
    for (int e = 1; e <= 16; e++) begin
      if (e == RstEdge) RST = 1'b1;
      @(posedge CLK); #1;
      if (e == RstEdge) begin
        RST = 1'b0;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", BUSY); end
        checks++;
        if ({HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, HUM_BCD, TEMP_BCD, ERR_CNT} !== 64'd0) begin
          failures++;
          $display("FAIL rst_mid_outputs got=%h %h %h %h %h %h %h exp=all zero",
                   HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, HUM_BCD, TEMP_BCD, ERR_CNT);
        end
      end
      if (DATA_VLD === 1'b1 || CRC_ERR === 1'b1) vld++;
    end
    checks++; if (vld !== 0) begin failures++; $display("FAIL rst_mid_pulses got=%0d exp=0", vld); end
  endtask

  task automatic test_saturation();
    int crc = 0;
    for (int n = 0; n < 300; n++) begin
      send(40'h0102030400);
      @(posedge CLK); #1;
      if (CRC_ERR === 1'b1) crc++;
      if (n == 254) begin
        checks++; if (ERR_CNT !== 8'd255) begin failures++; $display("FAIL sat_at_255 got=%0d exp=255", ERR_CNT); end
      end
    end
    checks++; if (crc !== 300) begin failures++; $display("FAIL sat_crc_pulses got=%0d exp=300", crc); end
    checks++; if (ERR_CNT !== 8'd255) begin failures++; $display("FAIL sat_err_cnt got=%0d exp=255", ERR_CNT); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_checksum_wrap();
    test_busy_drop();
    test_reset_mid_frame();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
